ldm_ctrl: RTL and testbench

Multi-cycle sequencer for ARMv4 LDM/STM block transfers.
- Accepts a cond-checked LDM/STM from the ID stage (is_ldm, P/U/L/W, reglist, base value, Rn code).
- Issues one word transfer per accepted memory beat, lowest register at lowest address, and stalls the front end until done.
- Then issues the optional base writeback.
- Sits beside EX/MEM; owns the memory port and the register-file write/read codes while busy.

---
 rtl/ldm_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ldm_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ldm_ctrl.sv
// LDM/STM block-transfer sequencer: one word per accepted memory beat, then optional base writeback.
// Optional `LDM_PC_FLUSH_EN adds an R15-load redirect (o_pc_load/o_pc_target) and delays o_done one cycle.
module ldm_ctrl #(
  parameter int ADDR_W = 32,
  parameter int STEP   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_ldm_p,
  input  logic              i_ldm_u,
  input  logic              i_ldm_l,
  input  logic              i_ldm_w,
  input  logic [15:0]       i_ldm_reglist,
  input  logic [3:0]        i_rn_code,
  input  logic [ADDR_W-1:0] i_base,
  output logic              o_stall,
  output logic              o_busy,
  output logic              o_mem_vld,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [ADDR_W-1:0] o_mem_wdata,
  input  logic              i_mem_rdy,
  input  logic [ADDR_W-1:0] i_mem_rdata,
  output logic [3:0]        o_st_rd_code,
  input  logic [ADDR_W-1:0] i_st_rd_data,
  output logic              o_ld_wr_vld,
  output logic [3:0]        o_ld_wr_code,
  output logic [ADDR_W-1:0] o_ld_wr_data,
  output logic              o_base_wb_vld,
  output logic [3:0]        o_base_wb_code,
  output logic [ADDR_W-1:0] o_base_wb_data,
  output logic              o_done,
`ifdef LDM_PC_FLUSH_EN
  output logic              o_pc_load,
  output logic [ADDR_W-1:0] o_pc_target,
`endif
  input  logic              i_flush
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_FIN, S_PCW} state_t;

  state_t            r_state;
  logic [15:0]       r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_final;
  logic [3:0]        r_rn;
  logic              r_l;
  logic              r_wb;
`ifdef LDM_PC_FLUSH_EN
  logic              r_pc;
`endif

  logic [4:0]        w_cnt;
  logic [3:0]        w_cur;
  logic [15:0]       w_mask_nxt;
  logic [ADDR_W-1:0] w_step;
  logic [ADDR_W-1:0] w_span;
  logic [ADDR_W-1:0] w_start_addr;
  logic [ADDR_W-1:0] w_final;
  logic              w_xfer;
  logic              w_fin;
  logic              w_beat;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < 16; i++) w_cnt = w_cnt + 5'(i_ldm_reglist[i]);
  end

  // Descending scan so the last hit is the lowest set bit.
  always_comb begin
    w_cur = '0;
    for (int i = 15; i >= 0; i--) if (r_mask[i]) w_cur = 4'(i);
  end

  assign w_mask_nxt = r_mask & ~(16'd1 << w_cur);
  assign w_step     = ADDR_W'(STEP);
  assign w_span     = ADDR_W'(w_cnt) * w_step;
  assign w_final    = i_ldm_u ? i_base + w_span : i_base - w_span;

  always_comb begin
    case ({i_ldm_p, i_ldm_u})
      2'b01:   w_start_addr = i_base;
      2'b11:   w_start_addr = i_base + w_step;
      2'b00:   w_start_addr = i_base - w_span + w_step;
      default: w_start_addr = i_base - w_span;
    endcase
  end

  assign w_xfer = (r_state == S_XFER);
  assign w_fin  = (r_state == S_FIN);
  assign w_beat = w_xfer & i_mem_rdy;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_addr  <= '0;
      r_final <= '0;
      r_rn    <= '0;
      r_l     <= 1'b0;
      r_wb    <= 1'b0;
`ifdef LDM_PC_FLUSH_EN
      r_pc    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_mask  <= i_ldm_reglist;
          r_addr  <= w_start_addr;
          r_final <= w_final;
          r_rn    <= i_rn_code;
          r_l     <= i_ldm_l;
          // A loaded base wins over the writeback.
          r_wb    <= i_ldm_w & ~(i_ldm_l & i_ldm_reglist[i_rn_code]);
`ifdef LDM_PC_FLUSH_EN
          r_pc    <= 1'b0;
`endif
          r_state <= (w_cnt != 5'd0) ? S_XFER : S_FIN;
        end
        S_XFER: if (i_mem_rdy) begin
          r_mask <= w_mask_nxt;
          r_addr <= r_addr + w_step;
`ifdef LDM_PC_FLUSH_EN
          if (r_l && w_cur == 4'd15) r_pc <= 1'b1;
`endif
          if (w_mask_nxt == 16'd0) r_state <= S_FIN;
        end
`ifdef LDM_PC_FLUSH_EN
        S_FIN:   r_state <= r_pc ? S_PCW : S_IDLE;
`else
        S_FIN:   r_state <= S_IDLE;
`endif
        default: r_state <= S_IDLE;
      endcase
      if (i_flush) begin
        r_state <= S_IDLE;
        r_mask  <= '0;
      end
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_stall        = o_busy | i_start;
  assign o_mem_vld      = w_xfer;
  assign o_mem_we       = w_xfer & ~r_l;
  assign o_mem_addr     = r_addr;
  assign o_st_rd_code   = w_cur;
  assign o_mem_wdata    = w_xfer ? i_st_rd_data : '0;
  assign o_ld_wr_vld    = w_beat & r_l;
  assign o_ld_wr_code   = w_cur;
  assign o_ld_wr_data   = i_mem_rdata;
  assign o_base_wb_vld  = w_fin & r_wb & ~i_flush;
  assign o_base_wb_code = r_rn;
  assign o_base_wb_data = r_final;
`ifdef LDM_PC_FLUSH_EN
  assign o_pc_load      = o_ld_wr_vld & (w_cur == 4'd15);
  assign o_pc_target    = i_mem_rdata & ~ADDR_W'(3);
  assign o_done         = ((w_fin & ~r_pc) | (r_state == S_PCW)) & ~i_flush;
`else
  assign o_done         = w_fin & ~i_flush;
`endif

endmodule

// File: tb/tb_ldm_ctrl.sv
// Scoreboard bench for ldm_ctrl: the driver pushes expected beats/writebacks, a monitor pops and compares.
module tb_ldm_ctrl;
  logic        i_clk = 1'b0;
  logic        i_rst_n, i_start, i_ldm_p, i_ldm_u, i_ldm_l, i_ldm_w;
  logic [15:0] i_ldm_reglist;
  logic [3:0]  i_rn_code;
  logic [31:0] i_base;
  logic        o_stall, o_busy, o_mem_vld, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_rdy;
  logic [31:0] i_mem_rdata;
  logic [3:0]  o_st_rd_code;
  logic [31:0] i_st_rd_data;
  logic        o_ld_wr_vld;
  logic [3:0]  o_ld_wr_code;
  logic [31:0] o_ld_wr_data;
  logic        o_base_wb_vld;
  logic [3:0]  o_base_wb_code;
  logic [31:0] o_base_wb_data;
  logic        o_done, i_flush;
`ifdef LDM_PC_FLUSH_EN
  logic        o_pc_load;
  logic [31:0] o_pc_target;
`endif

  ldm_ctrl #(.ADDR_W(32), .STEP(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_ldm_p(i_ldm_p),
    .i_ldm_u(i_ldm_u), .i_ldm_l(i_ldm_l), .i_ldm_w(i_ldm_w), .i_ldm_reglist(i_ldm_reglist),
    .i_rn_code(i_rn_code), .i_base(i_base), .o_stall(o_stall), .o_busy(o_busy),
    .o_mem_vld(o_mem_vld), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdy(i_mem_rdy), .i_mem_rdata(i_mem_rdata),
    .o_st_rd_code(o_st_rd_code), .i_st_rd_data(i_st_rd_data), .o_ld_wr_vld(o_ld_wr_vld),
    .o_ld_wr_code(o_ld_wr_code), .o_ld_wr_data(o_ld_wr_data), .o_base_wb_vld(o_base_wb_vld),
    .o_base_wb_code(o_base_wb_code), .o_base_wb_data(o_base_wb_data), .o_done(o_done),
`ifdef LDM_PC_FLUSH_EN
    .o_pc_load(o_pc_load), .o_pc_target(o_pc_target),
`endif
    .i_flush(i_flush)
  );

  always #5 i_clk = ~i_clk;

  // Register file and memory are pure functions so the model can predict data independently.
  function automatic logic [31:0] rf(input logic [3:0] c);
    return 32'hC0DE_0000 | {28'd0, c};
  endfunction
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  assign i_st_rd_data = rf(o_st_rd_code);
  assign i_mem_rdata  = memf(o_mem_addr);

  typedef struct {logic [31:0] addr; logic we; logic [3:0] code; logic [31:0] data;} beat_t;
  typedef struct {logic [3:0] code; logic [31:0] data;} wb_t;
  beat_t bq[$];
  wb_t   wbq[$];
  int    done_exp = 0;
  int    tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge i_clk) if (i_rst_n) begin
    if (o_mem_vld && i_mem_rdy) begin
      if (bq.size() == 0) chk("beat_unexpected", 1, 0);
      else begin
        beat_t b;
        b = bq.pop_front();
        chk("beat_addr", o_mem_addr, b.addr);
        chk("beat_we", {31'd0, o_mem_we}, {31'd0, b.we});
        if (b.we) begin
          chk("st_code", {28'd0, o_st_rd_code}, {28'd0, b.code});
          chk("st_data", o_mem_wdata, b.data);
        end else begin
          chk("ld_vld", {31'd0, o_ld_wr_vld}, 32'd1);
          chk("ld_code", {28'd0, o_ld_wr_code}, {28'd0, b.code});
          chk("ld_data", o_ld_wr_data, b.data);
        end
      end
    end else if (o_ld_wr_vld) chk("ld_spurious", 1, 0);
    if (o_base_wb_vld) begin
      if (wbq.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        wb_t w;
        w = wbq.pop_front();
        chk("wb_code", {28'd0, o_base_wb_code}, {28'd0, w.code});
        chk("wb_data", o_base_wb_data, w.data);
      end
    end
    if (o_done) begin
      if (done_exp == 0) chk("done_unexpected", 1, 0);
      else done_exp--;
    end
  end

  // mode 0: rdy=1, 1: random rdy, 2: rdy low for the first 3 transfer cycles.
  // fl >= 0 flushes while beat index fl is presented.
  task automatic run(input logic p, u, l, w, input logic [15:0] list, input logic [3:0] rn,
                     input logic [31:0] base, input int mode, input int fl);
    int n, k, cyc, acc;
    logic [31:0] lo;
    logic do_fl;
    n  = $countones(list);
    lo = u ? (p ? base + 32'd4 : base) : (p ? base - 32'(4*n) : base - 32'(4*n) + 32'd4);
    k  = 0;
    for (int r = 0; r < 16; r++) if (list[r]) begin
      beat_t b;
      b.addr = lo + 32'(4*k);
      b.we   = ~l;
      b.code = 4'(r);
      b.data = l ? memf(b.addr) : rf(4'(r));
      if (fl < 0 || k <= fl) bq.push_back(b);
      k++;
    end
    if (fl < 0) begin
      if (w && !(l && list[rn])) begin
        wb_t e;
        e.code = rn;
        e.data = u ? base + 32'(4*n) : base - 32'(4*n);
        wbq.push_back(e);
      end
      done_exp++;
    end
    @(posedge i_clk); #1;
    i_start = 1; i_ldm_p = p; i_ldm_u = u; i_ldm_l = l; i_ldm_w = w;
    i_ldm_reglist = list; i_rn_code = rn; i_base = base;
    #1 chk("stall_on_start", {31'd0, o_stall}, 32'd1);
    @(posedge i_clk); #1;
    i_start = 0;
    cyc = 0; acc = 0;
    while (o_busy && cyc < 200) begin
      do_fl = (fl >= 0) && (acc == fl) && o_mem_vld;
      case (mode)
        0:       i_mem_rdy = 1'b1;
        1:       i_mem_rdy = 1'($urandom_range(0, 1));
        default: i_mem_rdy = (cyc >= 3);
      endcase
      if (do_fl) i_mem_rdy = 1'b1;
      i_flush = do_fl;
      if (mode == 2 && cyc < 4) begin
        #1 chk("hold_vld", {31'd0, o_mem_vld}, 32'd1);
        chk("hold_addr", o_mem_addr, lo);
      end
      if (o_mem_vld && i_mem_rdy) acc++;
      @(posedge i_clk); #1;
      i_flush = 0;
      cyc++;
    end
    if (cyc >= 200) chk("timeout", 1, 0);
    if (mode == 0 && fl < 0) chk("busy_cycles", cyc, n + 1);
    if (fl >= 0) begin
      chk("flush_busy_cycles", cyc, fl + 1);
      chk("flush_stall_drop", {31'd0, o_stall}, 32'd0);
    end
    @(negedge i_clk);
    chk("bq_drained", bq.size(), 0);
    chk("wbq_drained", wbq.size(), 0);
    chk("done_seen", done_exp, 0);
  endtask

  initial begin
    i_rst_n = 0; i_start = 0; i_ldm_p = 0; i_ldm_u = 0; i_ldm_l = 0; i_ldm_w = 0;
    i_ldm_reglist = 0; i_rn_code = 0; i_base = 0; i_mem_rdy = 0; i_flush = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_stall", {31'd0, o_stall}, 0);
    chk("rst_mem_vld", {31'd0, o_mem_vld}, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_done", {31'd0, o_done}, 0);
    chk("rst_wb", {31'd0, o_base_wb_vld}, 0);
    i_rst_n = 1;
    run(0, 1, 1, 1, 16'h0016, 4'd0,  32'h100,  0, -1);  // LDMIA r0!,{r1,r2,r4}
    run(1, 0, 0, 1, 16'h4010, 4'd13, 32'h2000, 0, -1);  // STMDB r13!,{r4,r14}
    run(1, 1, 1, 0, 16'h0001, 4'd3,  32'h40,   2, -1);  // LDMIB r3,{r0} with rdy stalls
    run(0, 0, 1, 1, 16'h0060, 4'd5,  32'h80,   0, -1);  // LDMDA r5!,{r5,r6}
    run(0, 1, 1, 1, 16'h000F, 4'd0,  32'h300,  0, 1);   // flush on 2nd of 4 beats
    run(0, 1, 1, 1, 16'h0000, 4'd2,  32'h10,   0, -1);  // empty list
    run(0, 0, 0, 1, 16'h0000, 4'd7,  32'h10,   0, -1);  // empty list STMDA
    for (int t = 0; t < 40; t++) begin
      logic [15:0] lst;
      lst = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      run(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), lst,
          4'($urandom), $urandom, $urandom_range(0, 1), -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
